// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory between CPU and DMA
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_next;
  logic                last_grant;  // 1 = DMA was granted last
  logic                win;         // 1 = DMA owns the current access
  logic                grant, grant_dma;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [CNT_W-1:0]    cnt;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_dma  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant      = 1'b1;
          // on a tie the port that did not go last wins
          grant_dma  = dma_req && (!cpu_req || !last_grant);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      win        <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        win        <= grant_dma;
        last_grant <= grant_dma;
        lat_we     <= grant_dma ? dma_we    : cpu_we;
        lat_addr   <= grant_dma ? dma_addr  : cpu_addr;
        lat_wdata  <= grant_dma ? dma_wdata : cpu_wdata;
        cnt        <= CNT_W'(MEM_LAT - 1);
      end else if (state == BUSY) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else if (!lat_we) begin
          if (win) dma_rdata <= mem_rdata;
          else     cpu_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state == BUSY);
  assign mem_we    = mem_en && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_done  = (state == DONE) && !win;
  assign dma_done  = (state == DONE) && win;
  assign cpu_stall = cpu_req && !cpu_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at MEM_LAT=1 and MEM_LAT=3
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_req3, cpu_we, dma_req, dma_req3, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        cpu_done, cpu_stall, dma_done, mem_en, mem_we;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_done3, cpu_stall3, dma_done3, mem_en3, mem_we3;
  logic [31:0] cpu_rdata3, dma_rdata3, mem_addr3, mem_wdata3;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req3), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done3), .cpu_rdata(cpu_rdata3), .cpu_stall(cpu_stall3),
    .dma_req(dma_req3), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(dma_done3), .dma_rdata(dma_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst) begin
      vectors++;
      if ((mem_we && !mem_en) || (cpu_done && dma_done)) begin
        errors++;
        $display("FAIL u1_exclusive: we=%b en=%b cpu_done=%b dma_done=%b", mem_we, mem_en, cpu_done, dma_done);
      end
      if (cpu_done || dma_done) begin
        vectors++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL u1_unexpected_done: cpu_done=%b dma_done=%b at cycle %0d, none required", cpu_done, dma_done, cyc);
        end else begin
          e1 = q1.pop_front();
          if (dma_done !== e1.port || cyc != e1.cyc || (e1.port ? dma_rdata : cpu_rdata) !== e1.rdata) begin
            errors++;
            $display("FAIL u1_done: port=%0d cycle=%0d rdata=%h, required port=%0d cycle=%0d rdata=%h",
                     dma_done, cyc, e1.port ? dma_rdata : cpu_rdata, e1.port, e1.cyc, e1.rdata);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && (cpu_done3 || dma_done3)) begin
      vectors++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL u3_unexpected_done: cpu_done=%b dma_done=%b at cycle %0d, none required", cpu_done3, dma_done3, cyc);
      end else begin
        e3 = q3.pop_front();
        if (dma_done3 !== e3.port || cyc != e3.cyc || (e3.port ? dma_rdata3 : cpu_rdata3) !== e3.rdata) begin
          errors++;
          $display("FAIL u3_done: port=%0d cycle=%0d rdata=%h, required port=%0d cycle=%0d rdata=%h",
                   dma_done3, cyc, e3.port ? dma_rdata3 : cpu_rdata3, e3.port, e3.cyc, e3.rdata);
        end
      end
    end
  end

  // Single access on u1: done is required two cycles after the request is driven
  task automatic run1(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input logic [31:0] exp_rd, input logic [31:0] exp_other,
                      input int exp_stall);
    int en_cnt = 0;
    int st = 0;
    if (port == 1'b0) begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    end else begin
      dma_we = we; dma_addr = addr; dma_wdata = wd; dma_req = 1'b1;
    end
    mem_rdata = rd;
    q1.push_back('{port, exp_rd, cyc + 2});
    #1 st += int'(cpu_stall);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        check("run_mem_addr", mem_addr, addr);
        check("run_mem_we", 32'(mem_we), 32'(we));
        check("run_mem_wdata", mem_wdata, wd);
      end
      st += int'(cpu_stall);
      check("run_other_rdata", port ? cpu_rdata : dma_rdata, exp_other);
      if (port ? dma_done : cpu_done) begin
        cpu_req = 1'b0; dma_req = 1'b0;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    check("run_en_cycles", 32'(en_cnt), 32'd1);
    check("run_stall_cycles", 32'(st), 32'(exp_stall));
  endtask

  task automatic test_round_robin();
    int k;
    logic [31:0] seen[$];
    cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hAAAA0001;
    dma_we = 1'b1; dma_addr = 32'h200; dma_wdata = 32'hBBBB0002;
    k = cyc;
    q1.push_back('{1'b0, 32'hDEADBEEF, k + 2});
    q1.push_back('{1'b1, 32'h0,        k + 5});
    q1.push_back('{1'b0, 32'hDEADBEEF, k + 8});
    q1.push_back('{1'b1, 32'h0,        k + 11});
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (mem_en) seen.push_back(mem_addr);
      if (cyc == k + 11) begin
        cpu_req = 1'b0; dma_req = 1'b0;
      end
    end
    check("rr_access_count", 32'(seen.size()), 32'd4);
    for (int j = 0; j < 4; j++)
      if (j < seen.size()) check("rr_grant_order", seen[j], (j % 2) ? 32'h200 : 32'h100);
  endtask

  task automatic test_lat3();
    int k;
    int en_cnt = 0;
    cpu_we = 1'b0; cpu_addr = 32'h20; mem_rdata = 32'hA5A50003;
    k = cyc;
    q3.push_back('{1'b0, 32'hA5A50003, k + 4});
    cpu_req3 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (mem_en3) begin
        en_cnt++;
        check("lat3_mem_addr", mem_addr3, 32'h20);
      end
      if (i == 0) begin
        cpu_addr = 32'h99; cpu_req3 = 1'b0;
      end
    end
    check("lat3_en_cycles", 32'(en_cnt), 32'd3);
  endtask

  task automatic test_reset_abort();
    int k;
    logic [31:0] seen[$];
    dma_we = 1'b1; dma_addr = 32'h44; dma_wdata = 32'h77; dma_req = 1'b1;
    @(negedge clk);
    check("abort_busy_en", 32'(mem_en), 32'd1);
    rst = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    check("abort_cpu_rdata", cpu_rdata, 32'h0);
    check("abort_dma_rdata", dma_rdata, 32'h0);
    check("abort_dma_done", 32'(dma_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cpu_we = 1'b0; cpu_addr = 32'h30; dma_we = 1'b0; dma_addr = 32'h50; mem_rdata = 32'h1111;
    k = cyc;
    q1.push_back('{1'b0, 32'h1111, k + 2});
    q1.push_back('{1'b1, 32'h1111, k + 5});
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (mem_en) seen.push_back(mem_addr);
      if (cpu_done) cpu_req = 1'b0;
      if (dma_done) dma_req = 1'b0;
    end
    check("post_reset_count", 32'(seen.size()), 32'd2);
    if (seen.size() > 0) check("post_reset_first", seen[0], 32'h30);
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0; cpu_req3 = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_req3 = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dma_rdata", dma_rdata, 32'h0);
    check("rst_dones", {30'd0, cpu_done, dma_done}, 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_u3_mem_en", 32'(mem_en3), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run1(1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        2);
    run1(1'b1, 1'b1, 32'h40, 32'hCAFE0001, 32'h0,        32'h0,        32'hDEADBEEF, 0);
    test_round_robin();
    test_lat3();
    test_reset_abort();
    run1(1'b0, 1'b0, 32'h60, 32'h0,        32'h1234,     32'h1234,     32'h1111,     2);
    run1(1'b1, 1'b0, 32'h64, 32'h0,        32'h5678,     32'h5678,     32'h1234,     0);

    repeat (3) @(negedge clk);
    check("u1_pending_dones", 32'(q1.size()), 32'd0);
    check("u3_pending_dones", 32'(q3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters.
- Port 0 is the CPU (fetch and load/store, driven by IorD/MemRead/MemWrite).
- Port 1 is the DMA/program loader.
- Round-robin FSM serialises accesses, drives the memory, and returns a one-cycle done pulse plus registered read data. cpu_stall lets the control unit hold PCEn/IRWrite until the access completes.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles memory enable is held per access (>=1); rdata is valid at the end of the last such cycle

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU access request, level, held until cpu_done
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_done
- cpu_stall  out  1  cpu_req & ~cpu_done
- dma_req  in  1  DMA request, level
- dma_we  in  1  1=write
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_done  out  1  one-cycle completion pulse
- dma_rdata  out  DATA_W  DMA read data, valid with dma_done
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, last_grant=DMA (so the CPU wins the first tie).
  - All done outputs, mem_en and mem_we are 0.
  - mem_addr, mem_wdata, cpu_rdata and dma_rdata are 0.
  - The latency counter is 0.
  - Reset overrides every other event, including mid-BUSY. The aborted access produces no done pulse.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If no request, stay.
  - If exactly one request, grant it.
  - If both request, grant the port that is not last_grant.
  - On grant: latch winner id, we, addr and wdata into internal registers; set last_grant=winner; cnt=MEM_LAT-1; go BUSY.
- BUSY:
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched registers. Memory outputs are registered/latched and stable for the whole access.
  - If cnt!=0: decrement.
  - If cnt==0: on a read, capture mem_rdata into the winner's rdata register; go DONE.
- DONE:
  - Winner's done=1 for exactly this cycle; mem_en=0.
  - Go IDLE.
- Latency: request sampled in IDLE at edge t, done high during cycle t+MEM_LAT+1. Total MEM_LAT+2 cycles per access, including the IDLE arbitration cycle.
- Read data:
  - Each port's rdata register holds its value until that port's next read completes.
  - Writes and the other port's accesses leave it unchanged.
- Request deassertion:
  - Dropping req during BUSY does not abort; the access completes and done still pulses.
  - Inputs changing during BUSY have no effect, since the access uses latched values.
- Back-to-back:
  - A request still high in the DONE cycle is seen as new in the following IDLE cycle.
  - With both ports continuously requesting, grants strictly alternate. Neither port starves; its wait is bounded by one access.
- mem_we is never 1 while mem_en is 0.
- cpu_stall is combinational: high from cpu_req assertion until and excluding the cpu_done cycle.
- Only one done output is high in any cycle.

Test Plan:
- Reset, then CPU read addr 0x10, MEM_LAT=1, mem_rdata=0xDEADBEEF:
  - mem_en high exactly 1 cycle with mem_addr=0x10, mem_we=0.
  - cpu_done pulses 2 cycles after the request edge; cpu_rdata=0xDEADBEEF.
  - cpu_stall high for 2 cycles.
- DMA write 0xCAFE0001 to 0x40:
  - mem_en=mem_we=1 for 1 cycle with matching addr/wdata; dma_done pulses once.
  - dma_rdata unchanged (0).
  - cpu_done stays 0.
- Both requests asserted simultaneously after reset and held, four accesses:
  - Grant order CPU, DMA, CPU, DMA; done pulses alternate, 3 cycles apart at MEM_LAT=1.
- MEM_LAT=3, CPU read; cpu_addr changed and cpu_req dropped mid-BUSY:
  - mem_en high exactly 3 cycles with the original address.
  - cpu_done still pulses at request edge +4.
- rst driven low during BUSY of a DMA write:
  - Next cycle all outputs are at reset values; no dma_done.
  - After release, a simultaneous CPU/DMA request grants CPU first.
- CPU read completes (rdata=0x1234), then DMA read (rdata=0x5678):
  - cpu_rdata holds 0x1234 throughout; dma_rdata=0x5678.
